control_unit_fsm: RTL and testbench
===================================

// Module: control_unit_fsm
// PURPOSE
//  Hardwired control unit: the stage directly upstream of the ARM datapath. Reads the
//  instruction register and status flags back from the datapath and drives the 44-bit
//  control word each cycle. Sequences fetch, decode and execute for the supported ARM
//  subset: data-processing, LDR/STR immediate offset, B/BL. Memory waits are held until
//  the RAM raises MOC (memory operation complete).
// PARAMETERS
//  MOC_TIMEOUT  16  max cycles waited for moc before FAULT (only with CU_MOC_TIMEOUT_EN)
// PORTS
//  CLK           in   1   clock, rising edge
//  clear_n       in   1   async reset, active low
//  ir            in   32  instruction register contents from datapath
//  flags         in   4   status flags {N,Z,C,V} = [3:0]
//  moc           in   1   memory operation complete from RAM
//  control_word  out  44  datapath control word
//  state         out  5   current state encoding (debug)
//  fault         out  1   memory timeout fault, sticky until reset
// BEHAVIOUR
//  Control word fields:
//   [20:0] mux selects  [25:21] low enables (bit22=IR/MDR, bit23=MAR, bit25=SR)
//   [27:26] high enables  [32:28] register clears  [36:33] 0  [37] RF write
//   [42:38] RAM {size[1:0],rw,-,en}  [43] 0
//  Outputs are Moore: decoded from registered state only; ir/flags sampled in DECODE.
//  Reset (async, clear_n=0):
//   state=RESET; fault=0; control_word=44'h0_01F0_0000_0 (clears[32:28]=5'b11111, all else 0).
//   Releases to FETCH1 on the first CLK edge after deassertion.
//  States and transitions:
//   RESET  -> FETCH1
//   FETCH1: MAR<-R15 (addrB=01, shifter src outB, B-mux=11, ALU MOV 4'hD, MAR en) -> FETCH2
//   FETCH2: R15<-R15+4 (addrA=01, B-mux=01 const 4, ALU ADD 4'h4, wr addr=01, RF_RW=1);
//           RAM en, read, word -> FETCH3
//   FETCH3: hold RAM read, MDR en; stay while moc=0, -> FETCH4 on moc=1
//   FETCH4: IR<-MDR -> DECODE
//   DECODE: evaluate ir[31:28] against flags (all 15 ARM conds; 4'hF = never).
//           Cond false or unsupported class -> FETCH1.
//           ir[27:26]=00 -> DP_EXEC; 01 -> LS_ADDR; 10 with ir[25]=1 -> BL_LINK if ir[24] else BR_EXEC
//   DP_EXEC: Rd<-Rn op shifter_operand (SALU from ir[24:21]; imm if ir[25]); RF_RW=0 for
//            TST/TEQ/CMP/CMN (opcode 10xx); SR en iff ir[20] -> FETCH1
//   LS_ADDR: MAR<-Rn +/- imm12 (U=ir[23]) -> LS_MEM
//   LS_MEM:  RAM en, rw=~ir[20], size=byte if ir[22]; stay while moc=0; on moc:
//            load -> LS_WB, store -> FETCH1
//   LS_WB:   Rd<-MDR (B-mux=00, MOV) -> FETCH1
//   BL_LINK: R14<-R15 (wr addr=10) -> BR_EXEC
//   BR_EXEC: R15<-R15+branch_ext (B-mux=10, ADD) -> FETCH1
//   FAULT:   control_word all zero, fault=1, absorbing until reset
//  Boundary rules:
//   - moc high on the cycle a wait state is entered advances on the next edge (min 1 cycle/wait)
//   - moc outside FETCH3/LS_MEM ignored
//   - Rd=15 writes allowed; next FETCH1 uses the new R15
//   - reset mid-instruction aborts immediately; no partial RF/RAM write after clear_n falls
//  Latency (moc same-cycle): DP 6 cycles, LDR 8, STR 7, B 6, BL 7, cond-fail 5.
// CONFIGURATION
//  CU_MOC_TIMEOUT_EN defined:
//   - per-wait counter reset on entry to FETCH3/LS_MEM
//   - after MOC_TIMEOUT cycles without moc -> FAULT, fault=1
//  Not defined:
//   - waits are unbounded; FAULT state unreachable; fault tied 0
// TESTING
//  1 clear_n low 3 cycles -> control_word=44'h0_01F0_0000_0, state=RESET, fault=0;
//    release -> FETCH1 next edge
//  2 fetch ADD R1,R2,R3 (E0821003), moc after 2 wait cycles -> FETCH3 held 3 cycles;
//    DP_EXEC with RF_RW=1, SR en=0
//  3 MOVEQ R0,#1 (03A00001) with Z=0 -> DECODE straight to FETCH1, no RF_RW pulse
//  4 BL (EB000004) -> BL_LINK (wr addr=10, RF_RW=1), then BR_EXEC (B-mux=10, ADD)
//  5 LDR R1,[R2,#4] (E5921004), moc delayed 5 -> LS_MEM held 6 cycles, then LS_WB writes Rd
//  6 CU_MOC_TIMEOUT_EN, MOC_TIMEOUT=16, moc stuck 0 -> FAULT after 16 cycles in FETCH3;
//    fault=1 until clear_n

Source files
------------

// File: rtl/control_unit_fsm.sv
// Hardwired fetch/decode/execute sequencer driving the 44-bit ARM datapath control word.
// Define CU_MOC_TIMEOUT_EN to bound memory waits (MOC_TIMEOUT cycles) and enable the FAULT state.
module control_unit_fsm
`ifdef CU_MOC_TIMEOUT_EN
  #(parameter int MOC_TIMEOUT = 16)
`endif
  (
  input  logic        CLK,
  input  logic        clear_n,
  input  logic [31:0] ir,
  input  logic [3:0]  flags,
  input  logic        moc,
  output logic [43:0] control_word,
  output logic [4:0]  state,
  output logic        fault
);

  typedef enum logic [4:0] {
    S_RESET   = 5'd0,
    S_FETCH1  = 5'd1,
    S_FETCH2  = 5'd2,
    S_FETCH3  = 5'd3,
    S_FETCH4  = 5'd4,
    S_DECODE  = 5'd5,
    S_DP_EXEC = 5'd6,
    S_LS_ADDR = 5'd7,
    S_LS_MEM  = 5'd8,
    S_LS_WB   = 5'd9,
    S_BL_LINK = 5'd10,
    S_BR_EXEC = 5'd11,
    S_FAULT   = 5'd12
  } state_t;

  localparam logic [3:0] ALU_SUB = 4'h2;
  localparam logic [3:0] ALU_ADD = 4'h4;
  localparam logic [3:0] ALU_MOV = 4'hD;
  localparam logic [1:0] SEL_R15 = 2'b01;
  localparam logic [1:0] SEL_R14 = 2'b10;
  localparam logic [1:0] BMUX_MDR = 2'b00;
  localparam logic [1:0] BMUX_FOUR = 2'b01;
  localparam logic [1:0] BMUX_BRANCH = 2'b10;
  localparam logic [1:0] BMUX_SHIFTER = 2'b11;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_BYTE = 2'b00;

  state_t cur_state, next_state;
  logic   timed_out;

  logic [1:0] addr_a, addr_b, wr_sel, b_mux, ram_size;
  logic [3:0] alu_op;
  logic [4:0] clears;
  logic       shift_imm, mdr_en, ir_en, mar_en, sr_en, rf_rw, ram_rw, ram_en;

  logic unused_ir;
  assign unused_ir = ^ir[19:0];

  // Odd condition codes are the negation of the even code just below them.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cond)
      4'h0: cond_pass = z;
      4'h1: cond_pass = !z;
      4'h2: cond_pass = c;
      4'h3: cond_pass = !c;
      4'h4: cond_pass = n;
      4'h5: cond_pass = !n;
      4'h6: cond_pass = v;
      4'h7: cond_pass = !v;
      4'h8: cond_pass = c && !z;
      4'h9: cond_pass = !c || z;
      4'hA: cond_pass = (n == v);
      4'hB: cond_pass = (n != v);
      4'hC: cond_pass = !z && (n == v);
      4'hD: cond_pass = z || (n != v);
      4'hE: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

`ifdef CU_MOC_TIMEOUT_EN
  localparam int CNT_W = $clog2(MOC_TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;

  assign timed_out = (wait_cnt == CNT_W'(MOC_TIMEOUT - 1));
  assign fault     = (cur_state == S_FAULT);

  // Any state change restarts the count, so each wait state is timed from its entry.
  always_ff @(posedge CLK or negedge clear_n) begin
    if (!clear_n)                     wait_cnt <= '0;
    else if (cur_state != next_state) wait_cnt <= '0;
    else if (!timed_out)              wait_cnt <= wait_cnt + 1'b1;
  end
`else
  assign timed_out = 1'b0;
  assign fault     = 1'b0;
`endif

  always_ff @(posedge CLK or negedge clear_n) begin
    if (!clear_n) cur_state <= S_RESET;
    else          cur_state <= next_state;
  end

  always_comb begin
    next_state = cur_state;
    addr_a = 2'b00; addr_b = 2'b00; wr_sel = 2'b00; b_mux = BMUX_MDR;
    shift_imm = 1'b0; alu_op = 4'h0; clears = 5'b00000;
    mdr_en = 1'b0; ir_en = 1'b0; mar_en = 1'b0; sr_en = 1'b0; rf_rw = 1'b0;
    ram_size = 2'b00; ram_rw = 1'b0; ram_en = 1'b0;
    case (cur_state)
      S_RESET: begin
        clears = 5'b11111;
        next_state = S_FETCH1;
      end
      S_FETCH1: begin
        addr_b = SEL_R15; b_mux = BMUX_SHIFTER; alu_op = ALU_MOV; mar_en = 1'b1;
        next_state = S_FETCH2;
      end
      S_FETCH2: begin
        addr_a = SEL_R15; b_mux = BMUX_FOUR; alu_op = ALU_ADD; wr_sel = SEL_R15; rf_rw = 1'b1;
        ram_en = 1'b1; ram_size = SIZE_WORD;
        next_state = S_FETCH3;
      end
      S_FETCH3: begin
        ram_en = 1'b1; ram_size = SIZE_WORD; mdr_en = 1'b1;
        if (moc)            next_state = S_FETCH4;
        else if (timed_out) next_state = S_FAULT;
      end
      S_FETCH4: begin
        ir_en = 1'b1;
        next_state = S_DECODE;
      end
      // Unsupported classes and failed conditions fall back to the next fetch.
      S_DECODE: begin
        next_state = S_FETCH1;
        if (cond_pass(ir[31:28], flags)) begin
          case (ir[27:26])
            2'b00:   next_state = S_DP_EXEC;
            2'b01:   next_state = S_LS_ADDR;
            2'b10:   if (ir[25]) next_state = ir[24] ? S_BL_LINK : S_BR_EXEC;
            default: next_state = S_FETCH1;
          endcase
        end
      end
      S_DP_EXEC: begin
        b_mux = BMUX_SHIFTER; shift_imm = ir[25]; alu_op = ir[24:21];
        rf_rw = (ir[24:23] != 2'b10); sr_en = ir[20];
        next_state = S_FETCH1;
      end
      S_LS_ADDR: begin
        b_mux = BMUX_SHIFTER; shift_imm = 1'b1; alu_op = ir[23] ? ALU_ADD : ALU_SUB; mar_en = 1'b1;
        next_state = S_LS_MEM;
      end
      S_LS_MEM: begin
        ram_en = 1'b1; ram_rw = ~ir[20]; ram_size = ir[22] ? SIZE_BYTE : SIZE_WORD; mdr_en = ir[20];
        if (moc)            next_state = ir[20] ? S_LS_WB : S_FETCH1;
        else if (timed_out) next_state = S_FAULT;
      end
      S_LS_WB: begin
        b_mux = BMUX_MDR; alu_op = ALU_MOV; rf_rw = 1'b1;
        next_state = S_FETCH1;
      end
      S_BL_LINK: begin
        addr_b = SEL_R15; b_mux = BMUX_SHIFTER; alu_op = ALU_MOV; wr_sel = SEL_R14; rf_rw = 1'b1;
        next_state = S_BR_EXEC;
      end
      S_BR_EXEC: begin
        addr_a = SEL_R15; b_mux = BMUX_BRANCH; alu_op = ALU_ADD; wr_sel = SEL_R15; rf_rw = 1'b1;
        next_state = S_FETCH1;
      end
      S_FAULT:  next_state = S_FAULT;
      default:  next_state = S_RESET;
    endcase
  end

  assign control_word = {1'b0, ram_size, ram_rw, 1'b0, ram_en, rf_rw, 4'b0000, clears,
                         2'b00, sr_en, 1'b0, mar_en, ir_en, mdr_en, 8'h00,
                         alu_op, shift_imm, b_mux, wr_sel, addr_b, addr_a};
  assign state = cur_state;

endmodule

// File: tb/tb_control_unit_fsm.sv
// Self-checking bench for control_unit_fsm: directed and random instruction streams compared each
// cycle against a queue-based behavioural model; follows CU_MOC_TIMEOUT_EN like the design.
module tb_control_unit_fsm;

  localparam int MOC_TIMEOUT = 16;
  localparam logic [43:0] RESET_WORD = 44'h001F0000000;

  localparam logic [4:0] ST_RESET = 5'd0, ST_FETCH1 = 5'd1, ST_FETCH2 = 5'd2, ST_FETCH3 = 5'd3,
                         ST_FETCH4 = 5'd4, ST_DECODE = 5'd5, ST_DP = 5'd6, ST_LS_ADDR = 5'd7,
                         ST_LS_MEM = 5'd8, ST_LS_WB = 5'd9, ST_BL = 5'd10, ST_BR = 5'd11,
                         ST_FAULT = 5'd12;

  logic        CLK = 1'b0;
  logic        clear_n = 1'b0;
  logic [31:0] ir = '0;
  logic [3:0]  flags = '0;
  logic        moc = 1'b0;
  logic [43:0] control_word;
  logic [4:0]  state;
  logic        fault;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  st;
    logic [43:0] cw;
    logic        flt;
    logic        moc;
    logic        pin_en;
    logic [43:0] pin;
  } exp_t;

  exp_t q[$];

  control_unit_fsm dut (
    .CLK(CLK), .clear_n(clear_n), .ir(ir), .flags(flags), .moc(moc),
    .control_word(control_word), .state(state), .fault(fault)
  );

  always #5 CLK = ~CLK;

  // Even codes give a base predicate; the odd code above it is its negation.
  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  function automatic logic [43:0] cw_of(input logic [4:0] st, input logic [31:0] i);
    logic [43:0] w;
    w = '0;
    case (st)
      ST_RESET:   w[32:28] = 5'h1F;
      ST_FETCH1:  begin w[3:2] = 2'b01; w[7:6] = 2'b11; w[12:9] = 4'hD; w[23] = 1'b1; end
      ST_FETCH2:  begin w[1:0] = 2'b01; w[7:6] = 2'b01; w[12:9] = 4'h4; w[5:4] = 2'b01;
                        w[37] = 1'b1; w[38] = 1'b1; w[42:41] = 2'b10; end
      ST_FETCH3:  begin w[38] = 1'b1; w[42:41] = 2'b10; w[21] = 1'b1; end
      ST_FETCH4:  w[22] = 1'b1;
      ST_DP:      begin w[7:6] = 2'b11; w[8] = i[25]; w[12:9] = i[24:21];
                        w[37] = !(i[24] && !i[23]); w[25] = i[20]; end
      ST_LS_ADDR: begin w[7:6] = 2'b11; w[8] = 1'b1; w[12:9] = i[23] ? 4'h4 : 4'h2; w[23] = 1'b1; end
      ST_LS_MEM:  begin w[38] = 1'b1; w[40] = !i[20]; w[42:41] = i[22] ? 2'b00 : 2'b10; w[21] = i[20]; end
      ST_LS_WB:   begin w[12:9] = 4'hD; w[37] = 1'b1; end
      ST_BL:      begin w[3:2] = 2'b01; w[7:6] = 2'b11; w[12:9] = 4'hD; w[5:4] = 2'b10; w[37] = 1'b1; end
      ST_BR:      begin w[1:0] = 2'b01; w[7:6] = 2'b10; w[12:9] = 4'h4; w[5:4] = 2'b01; w[37] = 1'b1; end
      default:    w = '0;
    endcase
    return w;
  endfunction

  task automatic cmp(input string name, input logic [43:0] got, input logic [43:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, got, want);
    end
  endtask

  task automatic push(input logic [4:0] st, input logic m);
    exp_t e;
    e.st = st; e.cw = cw_of(st, ir); e.flt = (st == ST_FAULT); e.moc = m;
    e.pin_en = 1'b0; e.pin = '0;
    q.push_back(e);
  endtask

  task automatic waitPush(input logic [4:0] st, input int w, output bit ok);
    ok = 1'b1;
`ifdef CU_MOC_TIMEOUT_EN
    if (w >= MOC_TIMEOUT) begin
      for (int k = 0; k < MOC_TIMEOUT; k++) push(st, 1'b0);
      for (int k = 0; k < 4; k++) push(ST_FAULT, 1'($urandom_range(0, 1)));
      ok = 1'b0;
    end
`endif
    if (ok) begin
      for (int k = 0; k < w; k++) push(st, 1'b0);
      push(st, 1'b1);
    end
  endtask

  // Expected per-cycle trace of one instruction, starting in FETCH1.
  task automatic applyStimulus(input logic [31:0] ir_v, input logic [3:0] flags_v,
                               input int wf, input int wm);
    bit ok, pass;
    ir = ir_v; flags = flags_v;
    push(ST_FETCH1, 1'($urandom_range(0, 1)));
    push(ST_FETCH2, 1'($urandom_range(0, 1)));
    waitPush(ST_FETCH3, wf, ok);
    if (ok) begin
      push(ST_FETCH4, 1'($urandom_range(0, 1)));
      push(ST_DECODE, 1'($urandom_range(0, 1)));
      pass = cond_ok(ir_v[31:28], flags_v);
      if (pass && ir_v[27:26] == 2'b00) begin
        push(ST_DP, 1'($urandom_range(0, 1)));
      end else if (pass && ir_v[27:26] == 2'b01) begin
        push(ST_LS_ADDR, 1'($urandom_range(0, 1)));
        waitPush(ST_LS_MEM, wm, ok);
        if (ok && ir_v[20]) push(ST_LS_WB, 1'($urandom_range(0, 1)));
      end else if (pass && ir_v[27:25] == 3'b101) begin
        if (ir_v[24]) push(ST_BL, 1'($urandom_range(0, 1)));
        push(ST_BR, 1'($urandom_range(0, 1)));
      end
    end
  endtask

  task automatic pinFirst(input logic [4:0] st, input logic [43:0] val);
    bit done;
    done = 1'b0;
    for (int i = 0; i < q.size(); i++) begin
      if (!done && q[i].st == st) begin
        q[i].pin_en = 1'b1; q[i].pin = val; done = 1'b1;
      end
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmp("state", {39'b0, state}, {39'b0, e.st});
    cmp("control_word", control_word, e.cw);
    cmp("fault", {43'b0, fault}, {43'b0, e.flt});
    if (e.pin_en) cmp("pinned control_word", control_word, e.pin);
  endtask

  task automatic runQueue(input int max_cycles);
    exp_t e;
    int n;
    n = 0;
    while (q.size() > 0 && n < max_cycles) begin
      e = q.pop_front();
      checkOutput(e);
      moc = e.moc;
      @(negedge CLK);
      n++;
    end
    q.delete();
  endtask

  task automatic doReset();
    clear_n = 1'b0; moc = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      cmp("reset state", {39'b0, state}, {39'b0, ST_RESET});
      cmp("reset control_word", control_word, RESET_WORD);
      cmp("reset fault", {43'b0, fault}, 44'd0);
    end
    clear_n = 1'b1;
    @(negedge CLK);
    cmp("release to FETCH1", {39'b0, state}, {39'b0, ST_FETCH1});
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] ir_v;
    int r;
    doReset();

    applyStimulus(32'hE0821003, 4'h0, 2, 0);
    pinFirst(ST_FETCH1, 44'h00000801AC4);
    pinFirst(ST_FETCH3, 44'h44000200000);
    pinFirst(ST_DP, 44'h020000008C0);
    runQueue(1000);

    applyStimulus(32'h03A00001, 4'h0, 0, 0);
    pinFirst(ST_DECODE, 44'h0);
    runQueue(1000);

    applyStimulus(32'hEB000004, 4'h0, 0, 0);
    pinFirst(ST_BL, 44'h02000001AE4);
    pinFirst(ST_BR, 44'h02000000891);
    runQueue(1000);

    applyStimulus(32'hE5921004, 4'h0, 0, 5);
    pinFirst(ST_LS_MEM, 44'h44000200000);
    pinFirst(ST_LS_WB, 44'h02000001A00);
    runQueue(1000);

    applyStimulus(32'hE5821004, 4'h0, 1, 0);
    pinFirst(ST_LS_MEM, 44'h54000000000);
    runQueue(1000);

    applyStimulus(32'hE1520003, 4'h0, 0, 0);
    pinFirst(ST_DP, 44'h000020014C0);
    runQueue(1000);

    applyStimulus(32'hE08FF003, 4'h0, 0, 0);
    runQueue(1000);

    applyStimulus(32'hE5921004, 4'h0, 1, 3);
    runQueue(7);
    #2 clear_n = 1'b0;
    #1;
    cmp("abort state", {39'b0, state}, {39'b0, ST_RESET});
    cmp("abort control_word", control_word, RESET_WORD);
    @(negedge CLK);
    doReset();

`ifdef CU_MOC_TIMEOUT_EN
    applyStimulus(32'hE0821003, 4'h0, 100, 0);
    runQueue(1000);
    doReset();
`endif

    repeat (150) begin
      r = $urandom_range(0, 9);
      ir_v = $urandom;
      if (r < 4)      ir_v[27:26] = 2'b00;
      else if (r < 7) ir_v[27:26] = 2'b01;
      else if (r < 9) ir_v[27:25] = 3'b101;
      if ($urandom_range(0, 1) == 1) ir_v[31:28] = 4'hE;
      applyStimulus(ir_v, 4'($urandom), $urandom_range(0, 6), $urandom_range(0, 6));
      runQueue(1000);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
